// File: rtl/dmem_responder.sv
// Single-cycle data-memory responder: byte-lane word RAM plus an MMIO window
// (CYCLE, CONSOLE_TX, STATUS, SCRATCH). Define DMEM_CONSOLE_EN to build the console FIFO.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);

  localparam int unsigned RAM_WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW        = PW + 1;

  localparam logic [5:0] REG_CYCLE   = 6'd0;
  localparam logic [5:0] REG_TX      = 6'd1;
  localparam logic [5:0] REG_STATUS  = 6'd2;
  localparam logic [5:0] REG_SCRATCH = 6'd3;

  // Handshake: a console byte transfers on any posedge where con_valid && con_ready;
  // con_data holds steady while con_valid is high and the sink is not ready.

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  we);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  logic                  is_mmio;
  logic [5:0]            reg_sel;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  any_we;
  logic                  ram_we;
  logic                  scratch_we;
  logic                  unused_bits;

  assign is_mmio     = (daddr[31:8] == MMIO_BASE[31:8]);
  assign reg_sel     = daddr[7:2];
  assign ram_idx     = daddr[ADDR_WIDTH+1:2];
  assign any_we      = |dwe;
  assign ram_we      = !is_mmio && any_we;
  assign scratch_we  = is_mmio && (reg_sel == REG_SCRATCH) && any_we;

  // RAM: no reset, lanes merged at the edge so same-cycle reads see the old word.
  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_idx] <= lane_merge(mem_q[ram_idx], dwdata, dwe);
  end

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] scratch_q, scratch_d;

  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    scratch_d = scratch_q;
    if (scratch_we) scratch_d = lane_merge(scratch_q, dwdata, dwe);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= 32'd0;
      scratch_q <= 32'd0;
    end else begin
      cycle_q   <= cycle_d;
      scratch_q <= scratch_d;
    end
  end

  logic [31:0] status_word;

`ifdef DMEM_CONSOLE_EN
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fifo_empty, fifo_full;
  logic          pop, push_req, push_ok, ovf_set, ovf_clr;
  logic [31:0]   count_ext;
  logic [3:0]    count_sat;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    pop        = !fifo_empty && con_ready;
    push_req   = is_mmio && (reg_sel == REG_TX) && dwe[0];
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    push_ok    = push_req && (!fifo_full || pop);
    ovf_set    = push_req && !push_ok;
    ovf_clr    = is_mmio && (reg_sel == REG_STATUS) && any_we && dwdata[2];

    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);

    count_ext   = 32'(count_q);
    count_sat   = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    status_word = {20'd0, count_sat, 5'd0, ovf_q, fifo_full, fifo_empty};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= dwdata[7:0];
  end

  assign con_valid   = !fifo_empty;
  assign con_data    = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign unused_bits = ^daddr[1:0];
`else
  assign status_word = 32'h0000_0001;
  assign con_valid   = 1'b0;
  assign con_data    = 8'h00;
  assign unused_bits = ^{daddr[1:0], con_ready};
`endif

  always_comb begin
    drdata = 32'd0;
    if (is_mmio) begin
      case (reg_sel)
        REG_CYCLE:   drdata = cycle_q;
        REG_STATUS:  drdata = status_word;
        REG_SCRATCH: drdata = scratch_q;
        default:     drdata = 32'd0;
      endcase
    end else begin
      drdata = mem_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a queue/array reference model.
module tb_dmem_responder;
  localparam int          DEPTH     = 8;
  localparam int          RAM_WORDS = 1024;
  localparam logic [31:0] MMIO      = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE   = MMIO + 32'h0;
  localparam logic [31:0] A_TX      = MMIO + 32'h4;
  localparam logic [31:0] A_STATUS  = MMIO + 32'h8;
  localparam logic [31:0] A_SCR     = MMIO + 32'hC;
  localparam logic [31:0] A_NONE    = MMIO + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dwdata = 32'd0;
  logic [3:0]  dwe = 4'd0;
  logic [31:0] drdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;

  dmem_responder #(.ADDR_WIDTH(10), .MMIO_BASE(MMIO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] ram_m [int];
  logic [31:0] scr_m = 32'd0;
  logic        ovf_m = 1'b0;
  logic [31:0] cyc_m;
  logic [7:0]  exp_q[$];

  logic [31:0] last_rd;
  logic        last_valid;
  logic [7:0]  last_data;

  always @(posedge clk) cyc_m <= reset ? 32'd0 : cyc_m + 32'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_word, input logic [31:0] data,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] status_m();
`ifdef DMEM_CONSOLE_EN
    int n;
    n = exp_q.size();
    return {20'd0, 4'(n > 15 ? 15 : n), 5'd0, ovf_m, 1'(n == DEPTH), 1'(n == 0)};
`else
    return 32'h0000_0001;
`endif
  endfunction

  function automatic int word_key(input logic [31:0] addr);
    return int'((addr / 4) % RAM_WORDS);
  endfunction

  function automatic logic is_mmio_m(input logic [31:0] addr);
    return addr[31:8] == MMIO[31:8];
  endfunction

  // driver + scoreboard: apply one cycle of inputs, check outputs, advance the model
  task automatic step(input logic rst, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] we, input logic rdy);
    logic [31:0] exp_rd;
    logic        known;
    logic        pop;
    logic        set_ovf;
    int          key;
    @(negedge clk);
    reset = rst; daddr = addr; dwdata = data; dwe = we; con_ready = rdy;
    #1;
    known  = 1'b1;
    exp_rd = 32'd0;
    key    = word_key(addr);
    if (is_mmio_m(addr)) begin
      case (addr[7:2])
        6'd0:    exp_rd = cyc_m;
        6'd2:    exp_rd = status_m();
        6'd3:    exp_rd = scr_m;
        default: exp_rd = 32'd0;
      endcase
    end else if (ram_m.exists(key)) begin
      exp_rd = ram_m[key];
    end else begin
      known = 1'b0;
    end
    last_rd = drdata; last_valid = con_valid; last_data = con_data;
    if (known) check("drdata", drdata, exp_rd);
`ifdef DMEM_CONSOLE_EN
    check("con_valid", 32'(con_valid), 32'(exp_q.size() != 0));
    check("con_data", 32'(con_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
`else
    check("con_valid_off", 32'(con_valid), 32'd0);
    check("con_data_off", 32'(con_data), 32'd0);
`endif
    if (!is_mmio_m(addr) && we != 4'd0)
      ram_m[key] = merge(ram_m.exists(key) ? ram_m[key] : 32'd0, data, we);
    if (rst) begin
      scr_m = 32'd0;
      ovf_m = 1'b0;
      exp_q.delete();
    end else begin
      if (is_mmio_m(addr) && addr[7:2] == 6'd3 && we != 4'd0) scr_m = merge(scr_m, data, we);
`ifdef DMEM_CONSOLE_EN
      pop     = (exp_q.size() != 0) && rdy;
      set_ovf = 1'b0;
      if (pop) void'(exp_q.pop_front());
      if (is_mmio_m(addr) && addr[7:2] == 6'd1 && we[0]) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(data[7:0]);
        else set_ovf = 1'b1;
      end
      if (set_ovf) ovf_m = 1'b1;
      else if (is_mmio_m(addr) && addr[7:2] == 6'd2 && we != 4'd0 && data[2]) ovf_m = 1'b0;
`else
      pop = 1'b0;
      set_ovf = 1'b0;
`endif
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    logic [5:0]  sel_words[8];
    logic [7:0]  drain_exp[8];
    sel_words = '{6'd0, 6'd1, 6'd1, 6'd2, 6'd2, 6'd3, 6'd4, 6'd5};
    drain_exp = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h99};

    repeat (3) @(posedge clk);

    // reset state
    step(1'b1, A_STATUS, 32'd0, 4'd0, 1'b0);
    check("rst_status", last_rd, 32'h0000_0001);
    check("rst_valid", 32'(last_valid), 32'd0);
    check("rst_cdata", 32'(last_data), 32'd0);
    step(1'b1, A_SCR, 32'd0, 4'd0, 1'b0);
    check("rst_scratch", last_rd, 32'd0);

    // cycle counter after deassert
    step(1'b0, A_CYCLE, 32'd0, 4'd0, 1'b0); check("cycle_0", last_rd, 32'd0);
    step(1'b0, A_CYCLE, 32'd0, 4'd0, 1'b0); check("cycle_1", last_rd, 32'd1);
    step(1'b0, A_CYCLE, 32'd0, 4'd0, 1'b0); check("cycle_2", last_rd, 32'd2);

    // RAM byte lanes
    step(1'b0, 32'h10, 32'hAABB_CCDD, 4'b1111, 1'b0);
    step(1'b0, 32'h10, 32'h0000_0011, 4'b0001, 1'b0);
    step(1'b0, 32'h10, 32'd0, 4'd0, 1'b0); check("ram_lane0", last_rd, 32'hAABB_CC11);
    step(1'b0, 32'h10, 32'h5566_0000, 4'b1100, 1'b0);
    step(1'b0, 32'h10, 32'd0, 4'd0, 1'b0); check("ram_lane32", last_rd, 32'h5566_CC11);

    // aliasing
    step(1'b0, 32'h0000_0004, 32'h1234_5678, 4'b1111, 1'b0);
    step(1'b0, 32'h0000_1004, 32'd0, 4'd0, 1'b0); check("ram_alias", last_rd, 32'h1234_5678);

    // read during write returns old data
    step(1'b0, 32'h10, 32'hCAFE_F00D, 4'b1111, 1'b0); check("rdw_old", last_rd, 32'h5566_CC11);
    step(1'b0, 32'h12, 32'd0, 4'd0, 1'b0); check("rdw_new", last_rd, 32'hCAFE_F00D);

    // scratch lanes
    step(1'b0, A_SCR, 32'h1122_3344, 4'b1111, 1'b0);
    step(1'b0, A_SCR, 32'hAA00_0000, 4'b1000, 1'b0);
    step(1'b0, A_SCR, 32'd0, 4'd0, 1'b0); check("scratch_lane", last_rd, 32'hAA22_3344);
    step(1'b0, A_NONE, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    step(1'b0, A_NONE, 32'd0, 4'd0, 1'b0); check("unmapped_zero", last_rd, 32'd0);

    // random traffic over initialised words
    for (int i = 0; i < 16; i++) step(1'b0, 32'h80 + 32'(4 * i), $urandom, 4'b1111, 1'b0);
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      if ($urandom_range(0, 9) < 6)
        a = {1'b0, 19'($urandom), 10'(32 + $urandom_range(0, 15)), 2'($urandom)};
      else
        a = MMIO | {24'd0, sel_words[$urandom_range(0, 7)], 2'b00};
      step(1'b0, a, $urandom, w, 1'($urandom_range(0, 1)));
    end
    repeat (DEPTH + 1) step(1'b0, A_NONE, 32'd0, 4'd0, 1'b1);
    step(1'b0, A_STATUS, 32'h4, 4'b1111, 1'b0);

`ifdef DMEM_CONSOLE_EN
    // order and backpressure
    step(1'b0, A_TX, 32'h41, 4'b0001, 1'b0);
    step(1'b0, A_TX, 32'h42, 4'b0001, 1'b0);
    step(1'b0, A_TX, 32'h43, 4'b0001, 1'b0);
    step(1'b0, A_STATUS, 32'd0, 4'd0, 1'b0);
    check("con_status3", last_rd, 32'h0000_0300);
    check("con_hold_valid", 32'(last_valid), 32'd1);
    check("con_hold_data", 32'(last_data), 32'h41);
    step(1'b0, A_NONE, 32'd0, 4'd0, 1'b1); check("con_b0", 32'(last_data), 32'h41);
    step(1'b0, A_NONE, 32'd0, 4'd0, 1'b1); check("con_b1", 32'(last_data), 32'h42);
    step(1'b0, A_NONE, 32'd0, 4'd0, 1'b1); check("con_b2", 32'(last_data), 32'h43);
    step(1'b0, A_NONE, 32'd0, 4'd0, 1'b1); check("con_drained", 32'(last_valid), 32'd0);

    // overflow, W1C, full push with simultaneous pop
    for (int i = 0; i < 9; i++) step(1'b0, A_TX, 32'h50 + 32'(i), 4'b0001, 1'b0);
    step(1'b0, A_STATUS, 32'd0, 4'd0, 1'b0); check("ovf_status", last_rd, 32'h0000_0806);
    step(1'b0, A_STATUS, 32'h4, 4'b1111, 1'b0);
    step(1'b0, A_STATUS, 32'd0, 4'd0, 1'b0); check("ovf_w1c", last_rd, 32'h0000_0802);
    step(1'b0, A_TX, 32'h99, 4'b0001, 1'b1);
    step(1'b0, A_STATUS, 32'd0, 4'd0, 1'b0); check("full_push_pop", last_rd, 32'h0000_0802);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, A_NONE, 32'd0, 4'd0, 1'b1);
      check("ovf_drain", 32'(last_data), 32'(drain_exp[i]));
    end
    step(1'b0, A_STATUS, 32'd0, 4'd0, 1'b0); check("ovf_empty", last_rd, 32'h0000_0001);
`else
    for (int i = 0; i < 9; i++) step(1'b0, A_TX, 32'h41 + 32'(i), 4'b0001, 1'b0);
    step(1'b0, A_STATUS, 32'd0, 4'd0, 1'b0); check("off_status", last_rd, 32'h0000_0001);
    step(1'b0, A_TX, 32'd0, 4'd0, 1'b1); check("off_tx_read", last_rd, 32'd0);
`endif

    // cycle wrap
    @(negedge clk);
    reset = 1'b0; daddr = A_CYCLE; dwe = 4'd0; con_ready = 1'b0;
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    check("cycle_max", drdata, 32'hFFFF_FFFF);
    check("cycle_wrap_next", dut.cycle_d, 32'd0);
    release dut.cycle_q;

    // reset mid-stream
    step(1'b0, A_SCR, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    step(1'b0, A_TX, 32'h61, 4'b0001, 1'b0);
    step(1'b0, A_TX, 32'h62, 4'b0001, 1'b0);
    step(1'b0, A_TX, 32'h63, 4'b0001, 1'b0);
    step(1'b1, A_SCR, 32'd0, 4'd0, 1'b1);
    step(1'b0, A_CYCLE, 32'd0, 4'd0, 1'b0); check("mid_cycle", last_rd, 32'd0);
    check("mid_valid", 32'(last_valid), 32'd0);
    step(1'b0, A_STATUS, 32'd0, 4'd0, 1'b0); check("mid_status", last_rd, 32'h0000_0001);
    step(1'b0, A_SCR, 32'd0, 4'd0, 1'b0); check("mid_scratch", last_rd, 32'd0);
    step(1'b0, 32'h10, 32'd0, 4'd0, 1'b0); check("mid_ram", last_rd, 32'hCAFE_F00D);
    step(1'b0, 32'h1004, 32'd0, 4'd0, 1'b0); check("mid_ram_alias", last_rd, 32'h1234_5678);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
